// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle control FSM sequencing PC, IR, register file, memory, ALU and extender controls
module mc_ctrl #(
    parameter int S_W = 4
) (
    input  logic           CLK,
    input  logic           Reset,
    input  logic [5:0]     opcode,
    input  logic [5:0]     funct,
    input  logic           zero,
    output logic           pcW,
    output logic [1:0]     npcSel,
    output logic           irW,
    output logic           regW,
    output logic [1:0]     regDst,
    output logic [1:0]     wdSel,
    output logic           aluSrc,
    output logic [1:0]     extOp,
    output logic [2:0]     aluOp,
    output logic           memW,
    output logic [S_W-1:0] state
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEM_ADR = 4'd2,
        MEM_RD  = 4'd3,
        WB_MEM  = 4'd4,
        MEM_WR  = 4'd5,
        EXE_R   = 4'd6,
        WB_R    = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        EXE_I   = 4'd10,
        WB_I    = 4'd11
    } state_t;

    state_t cur, nxt;

    logic is_r, is_lw, is_sw, is_beq, is_ori, is_lui, is_j, is_jal, is_jr, r_alu;
    logic [2:0] r_op;

    assign is_r   = opcode == 6'b000000;
    assign is_lw  = opcode == 6'b100011;
    assign is_sw  = opcode == 6'b101011;
    assign is_beq = opcode == 6'b000100;
    assign is_ori = opcode == 6'b001101;
    assign is_lui = opcode == 6'b001111;
    assign is_j   = opcode == 6'b000010;
    assign is_jal = opcode == 6'b000011;
    assign is_jr  = is_r && funct == 6'b001000;
    assign r_alu  = is_r && (funct == 6'b100001 || funct == 6'b100011 || funct == 6'b101010);
    assign r_op   = funct == 6'b100011 ? 3'b001 : funct == 6'b101010 ? 3'b011 : 3'b000;
    assign state  = cur;

    // state register, asynchronously returned to FETCH by Reset
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) cur <= FETCH;
        else       cur <= nxt;
    end

    // next-state and per-state control outputs; everything forced low while Reset is high
    always_comb begin
        nxt    = FETCH;
        pcW    = 1'b0;
        npcSel = 2'b00;
        irW    = 1'b0;
        regW   = 1'b0;
        regDst = 2'b00;
        wdSel  = 2'b00;
        aluSrc = 1'b0;
        extOp  = 2'b00;
        aluOp  = 3'b000;
        memW   = 1'b0;
        case (cur)
            FETCH: begin
                nxt = DECODE;
                irW = 1'b1;
                pcW = 1'b1;
            end
            DECODE: nxt = (is_lw || is_sw) ? MEM_ADR :
                          r_alu ? EXE_R :
                          (is_jr || is_j || is_jal) ? JUMP :
                          is_beq ? BRANCH :
                          (is_ori || is_lui) ? EXE_I : FETCH;
            MEM_ADR, MEM_RD, WB_MEM, MEM_WR: begin
                nxt    = cur == MEM_ADR ? (is_lw ? MEM_RD : MEM_WR) : cur == MEM_RD ? WB_MEM : FETCH;
                aluSrc = 1'b1;
                extOp  = 2'b01;
                regW   = cur == WB_MEM;
                wdSel  = cur == WB_MEM ? 2'b01 : 2'b00;
                memW   = cur == MEM_WR;
            end
            EXE_R, WB_R: begin
                nxt    = cur == EXE_R ? WB_R : FETCH;
                aluOp  = r_op;
                regW   = cur == WB_R;
                regDst = cur == WB_R ? 2'b01 : 2'b00;
            end
            EXE_I, WB_I: begin
                nxt    = cur == EXE_I ? WB_I : FETCH;
                aluSrc = 1'b1;
                aluOp  = 3'b010;
                extOp  = is_lui ? 2'b10 : 2'b00;
                regW   = cur == WB_I;
            end
            BRANCH: begin
                aluOp  = 3'b001;
                npcSel = 2'b01;
                pcW    = zero;
            end
            JUMP: begin
                pcW    = 1'b1;
                npcSel = is_jr ? 2'b11 : 2'b10;
                regW   = is_jal;
                regDst = is_jal ? 2'b10 : 2'b00;
                wdSel  = is_jal ? 2'b10 : 2'b00;
            end
            default: nxt = FETCH;
        endcase
        if (Reset) begin
            pcW    = 1'b0;
            npcSel = 2'b00;
            irW    = 1'b0;
            regW   = 1'b0;
            regDst = 2'b00;
            wdSel  = 2'b00;
            aluSrc = 1'b0;
            extOp  = 2'b00;
            aluOp  = 3'b000;
            memW   = 1'b0;
        end
    end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: scoreboard bench for the multicycle control FSM
module tb_mc_ctrl;
    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       pcW, irW, regW, aluSrc, memW;
    logic [1:0] npcSel, regDst, wdSel, extOp;
    logic [2:0] aluOp;
    logic [3:0] state;
    logic [19:0] dv;
    logic [19:0] sbq[$];
    int n_chk = 0;
    int n_fail = 0;

    mc_ctrl #(.S_W(4)) dut (
        .CLK(CLK), .Reset(Reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pcW(pcW), .npcSel(npcSel), .irW(irW), .regW(regW), .regDst(regDst),
        .wdSel(wdSel), .aluSrc(aluSrc), .extOp(extOp), .aluOp(aluOp),
        .memW(memW), .state(state)
    );

    always #5 CLK = ~CLK;

    assign dv = {state, pcW, npcSel, irW, regW, regDst, wdSel, aluSrc, extOp, aluOp, memW};

    task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // expected outputs for a given state, taken straight from the per-state output table
    function automatic logic [19:0] model(input int st, input logic [5:0] op, input logic [5:0] fn, input logic z);
        logic pcw, irw, regw, alus, memw;
        logic [1:0] npc, rd, wd, ext;
        logic [2:0] alu;
        {pcw, irw, regw, alus, memw, npc, rd, wd, ext, alu} = '0;
        case (st)
            0: begin irw = 1; pcw = 1; end
            2, 3, 4, 5: begin
                alus = 1; ext = 2'b01;
                if (st == 4) begin regw = 1; wd = 2'b01; end
                if (st == 5) memw = 1;
            end
            6, 7: begin
                alu = fn == 6'b100011 ? 3'b001 : fn == 6'b101010 ? 3'b011 : 3'b000;
                if (st == 7) begin regw = 1; rd = 2'b01; end
            end
            10, 11: begin
                alus = 1; alu = 3'b010;
                ext = op == 6'b001111 ? 2'b10 : 2'b00;
                if (st == 11) regw = 1;
            end
            8: begin alu = 3'b001; npc = 2'b01; pcw = z; end
            9: begin
                pcw = 1;
                npc = op == 6'b000000 ? 2'b11 : 2'b10;
                if (op == 6'b000011) begin regw = 1; rd = 2'b10; wd = 2'b10; end
            end
            default: ;
        endcase
        return {4'(st), pcw, npc, irw, regw, rd, wd, alus, ext, alu, memw};
    endfunction

    task automatic drain(input string tag);
        logic [19:0] e;
        int budget = 16;
        while (sbq.size() > 0 && budget > 0) begin
            #1;
            e = sbq.pop_front();
            check(tag, dv, e);
            check({tag, "_excl"}, {19'd0, regW & memW}, 20'd0);
            @(negedge CLK);
            budget--;
        end
        if (sbq.size() != 0) begin
            check({tag, "_budget"}, 20'(sbq.size()), 20'd0);
            sbq.delete();
        end
    endtask

    // drive one instruction and push its expected per-cycle outputs; -1 ends the state list
    task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int s2, input int s3, input int s4);
        opcode = op; funct = fn; zero = z;
        sbq.push_back(model(0, op, fn, z));
        sbq.push_back(model(1, op, fn, z));
        if (s2 >= 0) sbq.push_back(model(s2, op, fn, z));
        if (s3 >= 0) sbq.push_back(model(s3, op, fn, z));
        if (s4 >= 0) sbq.push_back(model(s4, op, fn, z));
        drain(tag);
    endtask

    initial begin
        @(negedge CLK);
        check("rst_hold", dv, 20'd0);
        @(negedge CLK);
        check("rst_hold2", dv, 20'd0);
        Reset = 1'b0;
        run("lw", 6'b100011, 6'd0, 1'b0, 2, 3, 4);
        run("sw", 6'b101011, 6'd0, 1'b0, 2, 5, -1);
        run("addu", 6'b000000, 6'b100001, 1'b0, 6, 7, -1);
        run("subu", 6'b000000, 6'b100011, 1'b0, 6, 7, -1);
        run("slt", 6'b000000, 6'b101010, 1'b0, 6, 7, -1);
        run("ori", 6'b001101, 6'd0, 1'b0, 10, 11, -1);
        run("lui", 6'b001111, 6'd0, 1'b0, 10, 11, -1);
        run("beq_z1", 6'b000100, 6'd0, 1'b1, 8, -1, -1);
        run("beq_z0", 6'b000100, 6'd0, 1'b0, 8, -1, -1);
        run("j", 6'b000010, 6'd0, 1'b0, 9, -1, -1);
        run("jal", 6'b000011, 6'd0, 1'b0, 9, -1, -1);
        run("jr", 6'b000000, 6'b001000, 1'b0, 9, -1, -1);
        run("ill_op", 6'b111111, 6'd0, 1'b0, -1, -1, -1);
        run("ill_fn", 6'b000000, 6'b000000, 1'b0, -1, -1, -1);
        opcode = 6'b100011; funct = 6'd0; zero = 1'b0;
        sbq.push_back(model(0, opcode, funct, zero));
        sbq.push_back(model(1, opcode, funct, zero));
        sbq.push_back(model(2, opcode, funct, zero));
        sbq.push_back(model(3, opcode, funct, zero));
        drain("lw_pre");
        #2 Reset = 1'b1;
        #1 check("rst_async", dv, 20'd0);
        @(negedge CLK);
        check("rst_mid", dv, 20'd0);
        Reset = 1'b0;
        run("lw_after_rst", 6'b100011, 6'd0, 1'b0, 2, 3, 4);
        #1 check("final_fetch", dv, model(0, opcode, funct, zero));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
